// File: rtl/single_protocol_transmitter_pkg.sv
// Shared constants for the reply-packet transmitter: byte width, CRC8
// parameters and FSM state encoding.
package single_protocol_transmitter_pkg;

  localparam int BYTE_LENGTH = 8;

  // CRC-8/SMBUS style: poly x^8+x^2+x+1, MSB-first, no reflection, no xorout
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

endpackage

// File: rtl/single_protocol_transmitter_crc8_byte_update.sv
// One-byte CRC8 step, fully combinational. Also usable by the receiver so
// both ends agree on the exact bit order.
module crc8_byte_update
  import single_protocol_transmitter_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  // Eight unrolled MSB-first shift/XOR steps
  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    crc_out = c;
  end

endmodule

// File: rtl/single_protocol_transmitter.sv
// Frames one reply packet [cmd][data 0..size-1][crc8] and hands it to the
// UART TX engine one byte at a time over a send/busy handshake.
// Byte width is fixed by the package; the payload width follows from it.
module single_protocol_transmitter
  import single_protocol_transmitter_pkg::*;
#(
  parameter int BUFFER_LENGTH        = 6,
  parameter int TOTAL_BITS           = BYTE_LENGTH * BUFFER_LENGTH,
  parameter int COUNTER_SIZE         = 8,
  parameter int TIMEOUT_COUNTER_SIZE = 32,
  parameter int TIMEOUT_MAX_VAL      = 10000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BYTE_LENGTH-1:0]  out_cmd,
  input  logic [TOTAL_BITS-1:0]   out_data,
  input  logic [COUNTER_SIZE-1:0] out_data_size,
  input  logic                    flush,
  output logic                    busy,
  output logic                    complete,
  output logic                    error,
  output logic [BYTE_LENGTH-1:0]  tx_byte,
  output logic                    tx_send,
  input  logic                    tx_busy
);

  localparam logic [COUNTER_SIZE-1:0]         MAX_SIZE = COUNTER_SIZE'(BUFFER_LENGTH);
  localparam logic [TIMEOUT_COUNTER_SIZE-1:0] TO_LAST  = TIMEOUT_COUNTER_SIZE'(TIMEOUT_MAX_VAL - 1);

  logic [2:0]                                     state;
  logic [BYTE_LENGTH-1:0]                         cmd_q;
  logic [BUFFER_LENGTH-1:0][BYTE_LENGTH-1:0]      data_q;
  logic [COUNTER_SIZE-1:0]                        size_q;
  logic [COUNTER_SIZE-1:0]                        idx_q;
  logic [7:0]                                     crc_q;
  logic [7:0]                                     crc_next;
  logic [TIMEOUT_COUNTER_SIZE-1:0]                timeout_cnt;
  logic [BYTE_LENGTH-1:0]                         cur_byte;
  logic                                           is_body;
  logic                                           timeout_hit;
  logic                                           last_byte;

  // idx 0 is the command, 1..size the payload, size+1 the CRC itself
  assign is_body     = (idx_q <= size_q);
  assign last_byte   = (idx_q >= size_q + COUNTER_SIZE'(1));
  assign timeout_hit = (timeout_cnt >= TO_LAST);

  // Select the byte for the current index
  always_comb begin
    cur_byte = crc_q;
    if (idx_q == '0)
      cur_byte = cmd_q;
    else if (is_body)
      for (int k = 0; k < BUFFER_LENGTH; k++)
        if (idx_q == COUNTER_SIZE'(k + 1)) cur_byte = data_q[k];
  end

  crc8_byte_update u_crc (
    .crc_in  (crc_q),
    .data_in (cur_byte),
    .crc_out (crc_next)
  );

  // Packet FSM: latch request, walk bytes through the UART handshake, guard each with a timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      complete    <= 1'b0;
      error       <= 1'b0;
      tx_send     <= 1'b0;
      tx_byte     <= '0;
      crc_q       <= CRC8_INIT;
      idx_q       <= '0;
      size_q      <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      timeout_cnt <= '0;
    end else begin
      tx_send  <= 1'b0;
      complete <= 1'b0;
      error    <= 1'b0;
      if (flush) begin
        // abort wins over everything but reset; a same-cycle start is dropped
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cmd_q  <= out_cmd;
              data_q <= out_data;
              size_q <= (out_data_size > MAX_SIZE) ? MAX_SIZE : out_data_size;
              idx_q  <= '0;
              crc_q  <= CRC8_INIT;
              busy   <= 1'b1;
              state  <= ST_SEND;
            end
          end
          ST_SEND: begin
            tx_byte     <= cur_byte;
            tx_send     <= 1'b1;
            if (is_body) crc_q <= crc_next;
            timeout_cnt <= '0;
            state       <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (timeout_hit) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
              if (tx_busy) state <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (timeout_hit) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
              if (!tx_busy) begin
                if (last_byte) state <= ST_FINISH;
                else begin
                  idx_q <= idx_q + 1'b1;
                  state <= ST_SEND;
                end
              end
            end
          end
          ST_FINISH: begin
            complete <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
